pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the five-stage MIPS pipeline. Drives the write-enable (we) and clear (reset) inputs of the fflop pipeline registers IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC register. Resolves load-use hazards, taken branches, data-memory wait states and exceptions. Keeps a free-running stall-cycle performance counter.

Parameters:
REG_W, 5, register-specifier width
DRAIN_CYCLES, 2, cycles the front end is held after an exception redirect (1..15)
CNT_W, 32, stall counter width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low; sampled on rising clk
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
ex_rt  in  REG_W  destination of instruction in EX
ex_memread  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM stage has an active data access
mem_ready  in  1  data memory completes access this cycle
mem_exc  in  1  MEM-stage instruction raises an exception
pc_we  out  1  PC load enable
pc_sel_exc  out  1  PC mux selects exception vector
we_if_id, we_id_ex, we_ex_mem, we_mem_wb  out  1 each  pipeline register enables
flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  active-high clear to the fflop reset inputs
epc_we  out  1  capture EPC/cause
mem_abort  out  1  cancel in-flight data access
stall_count  out  CNT_W  stall-cycle counter

Behaviour:
- State: RUN, MEM_WAIT, DRAIN. Registered: state, drain counter (4 bit), stall_count. All other outputs are combinational from state and inputs, so a stall takes effect in the same cycle.
- While reset=0 at a clk edge: state<=RUN, drain counter<=0, stall_count<=0. Outputs during reset are forced: all we=0, all flush=1, pc_we=0, pc_sel_exc=0, epc_we=0, mem_abort=0.
- Default (RUN, no event): all we=1, all flush=0, pc_we=1.
- Priority per cycle: exception > memory wait > branch > load-use.
- Exception (mem_exc=1, state != DRAIN):
  - flush_if_id, flush_id_ex, flush_ex_mem and flush_mem_wb are 1.
  - pc_we=1, pc_sel_exc=1, epc_we=1.
  - If mem_req and !mem_ready, mem_abort=1.
  - Next state is DRAIN with the counter loaded to DRAIN_CYCLES.
- Memory wait (mem_req=1 and mem_ready=0):
  - All we=0, pc_we=0, no flush; next state is MEM_WAIT.
  - In MEM_WAIT, the cycle with mem_ready=1 drives default RUN outputs, except that branch and load-use still apply. Next state is RUN.
- Branch (ex_branch_taken=1): flush_if_id=1, flush_id_ex=1, all we=1, pc_we=1. The load-use check is suppressed because its instruction is on the wrong path.
- Load-use: ex_memread and ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt).
  - pc_we=0, we_if_id=0, flush_id_ex=1.
  - we_id_ex, we_ex_mem, we_mem_wb are 1. This inserts exactly one bubble.
- DRAIN:
  - pc_we=0, we_if_id=0, flush_if_id=1, flush_id_ex=1.
  - we_ex_mem and we_mem_wb are 1.
  - mem_exc, ex_branch_taken and the hazard inputs are ignored.
  - The counter decrements each cycle. The cycle it reads 1 is the last DRAIN cycle; next state is RUN.
- stall_count increments, wrapping, on every non-reset cycle with pc_we=0.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN immediately; no abort pulse is produced.

Decomposition:
- Shared package pipe_pkg: state encoding (RUN=0, MEM_WAIT=1, DRAIN=2) and the ZERO_REG constant 5'd0.
- One sub-module, hazard_detect: the combinational load-use compare, output `hazard`.
- The FSM, counters and output mux live in pipeline_ctrl.

Test Plan:
- Reset=0 for 2 cycles, then release with idle inputs -> during reset all flush=1 and all we=0; the first cycle after release gives all we=1, pc_we=1, stall_count=0.
- Load-use bubble: ex_memread=1, ex_rt=8, id_rs=8 for one cycle.
  - Same cycle: pc_we=0, we_if_id=0, flush_id_ex=1.
  - stall_count becomes 1.
  - ex_rt=0 with id_rs=0 gives no stall.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1.
  - All we=0 for 3 cycles, state MEM_WAIT, stall_count +3.
  - The 4th cycle has all we=1.
- Branch plus load-use together: ex_branch_taken=1 and the load-use condition true -> flush_if_id=1, flush_id_ex=1, pc_we=1, no stall.
- Exception during wait: mem_exc=1, mem_req=1, mem_ready=0.
  - Same cycle: mem_abort=1, epc_we=1, pc_sel_exc=1, 4 flushes.
  - The next 2 cycles (DRAIN_CYCLES=2) have pc_we=0.
  - A mem_exc pulse inside DRAIN is ignored.
  - RUN resumes on cycle 4.
- Reset asserted mid-DRAIN -> state RUN after the edge, and stall_count reads 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_pkg;

  // Sequencer states: normal issue, waiting on data memory, draining after an exception
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  // Register $zero never carries a real dependency
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory status inputs and pipeline-register control outputs of the sequencer.
interface pipeline_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] ex_rt;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             mem_exc;

  logic             pc_we;
  logic             pc_sel_exc;
  logic             we_if_id;
  logic             we_id_ex;
  logic             we_ex_mem;
  logic             we_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             flush_mem_wb;
  logic             epc_we;
  logic             mem_abort;
  logic [CNT_W-1:0] stall_count;

  // Datapath side: reports pipeline status, receives enables and clears
  modport master (
    output id_rs, id_rt, ex_rt, ex_memread, ex_branch_taken,
           mem_req, mem_ready, mem_exc,
    input  pc_we, pc_sel_exc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           epc_we, mem_abort, stall_count
  );

  // Sequencer side
  modport slave (
    input  id_rs, id_rt, ex_rt, ex_memread, ex_branch_taken,
           mem_req, mem_ready, mem_exc,
    output pc_we, pc_sel_exc, we_if_id, we_id_ex, we_ex_mem, we_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           epc_we, mem_abort, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands of the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_memread,
  output logic             hazard
);

  // A load writing a real register that ID is about to read needs one bubble
  always_comb begin
    hazard = ex_memread && (ex_rt != REG_W'(ZERO_REG)) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: drives pipeline-register
// enables and clears, the PC enable, exception capture and a stall-cycle counter.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  state_t           state;
  logic [3:0]       drain_cnt;
  logic [CNT_W-1:0] stall_count_q;
  logic             hazard;
  logic             wait_evt;
  logic             exc_evt;
  logic             pc_we_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .ex_rt      (bus.ex_rt),
    .ex_memread (bus.ex_memread),
    .hazard     (hazard)
  );

  assign wait_evt        = bus.mem_req && !bus.mem_ready;
  assign exc_evt         = bus.mem_exc && (state != DRAIN);
  assign bus.pc_we       = pc_we_c;
  assign bus.stall_count = stall_count_q;

  // Output mux, combinational so stalls and flushes act in the same cycle; priority exception > wait > branch > load-use
  always_comb begin
    pc_we_c          = 1'b1;
    bus.pc_sel_exc   = 1'b0;
    bus.epc_we       = 1'b0;
    bus.mem_abort    = 1'b0;
    bus.we_if_id     = 1'b1;
    bus.we_id_ex     = 1'b1;
    bus.we_ex_mem    = 1'b1;
    bus.we_mem_wb    = 1'b1;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    bus.flush_mem_wb = 1'b0;
    if (!reset) begin
      pc_we_c          = 1'b0;
      bus.we_if_id     = 1'b0;
      bus.we_id_ex     = 1'b0;
      bus.we_ex_mem    = 1'b0;
      bus.we_mem_wb    = 1'b0;
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
      bus.flush_mem_wb = 1'b1;
    end else if (state == DRAIN) begin
      pc_we_c         = 1'b0;
      bus.we_if_id    = 1'b0;
      bus.flush_if_id = 1'b1;
      bus.flush_id_ex = 1'b1;
    end else if (exc_evt) begin
      bus.flush_if_id  = 1'b1;
      bus.flush_id_ex  = 1'b1;
      bus.flush_ex_mem = 1'b1;
      bus.flush_mem_wb = 1'b1;
      bus.pc_sel_exc   = 1'b1;
      bus.epc_we       = 1'b1;
      bus.mem_abort    = wait_evt;
    end else if (wait_evt) begin
      pc_we_c       = 1'b0;
      bus.we_if_id  = 1'b0;
      bus.we_id_ex  = 1'b0;
      bus.we_ex_mem = 1'b0;
      bus.we_mem_wb = 1'b0;
    end else if (bus.ex_branch_taken) begin
      bus.flush_if_id = 1'b1;
      bus.flush_id_ex = 1'b1;
    end else if (hazard) begin
      pc_we_c         = 1'b0;
      bus.we_if_id    = 1'b0;
      bus.flush_id_ex = 1'b1;
    end
  end

  // Sequencer state, drain countdown and stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RUN;
      drain_cnt     <= 4'd0;
      stall_count_q <= '0;
    end else begin
      if (!pc_we_c) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
      case (state)
        DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) begin
            state <= RUN;
          end
        end
        default: begin
          if (exc_evt) begin
            state     <= DRAIN;
            drain_cnt <= 4'(DRAIN_CYCLES);
          end else if (wait_evt) begin
            state <= MEM_WAIT;
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end

endmodule
